load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter SHALL be: ACK_TIMEOUT, 16, max cycles in REQ awaiting mem_ack before bus error (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 start  input  1  instruction in execute requests an access; level, held until busy=0.
REQ-005 opcode  input  5  instruction opcode[6:2]; only LOAD/STORE codes start an access.
REQ-006 func3  input  3  access width/sign (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-007 addr  input  32  effective address (ALU sum rs1+imm).
REQ-008 store_data  input  32  rs2 value.
REQ-009 busy  output  1  stall PC/register writeback this cycle.
REQ-010 done  output  1  one-cycle pulse; load_data/error flags valid.
REQ-011 load_data  output  32  extended load result, registered.
REQ-012 misalign  output  1  misaligned or unsupported-width access, valid with done.
REQ-013 bus_err  output  1  ack timeout, valid with done.
REQ-014 mem_req, mem_we  output  1 each  memory request / write strobe, registered.
REQ-015 mem_addr  output  32  {addr[31:2],2'b00}; mem_be output 4 byte enables; mem_wdata output 32 lane-replicated data.
REQ-016 mem_rdata  input  32  read word; mem_ack input 1 access complete, sampled only in REQ.

Function
REQ-017 FSM states SHALL be IDLE, REQ, DONE.
REQ-018 IDLE: start=1 with LOAD/STORE opcode SHALL latch addr, func3, opcode, byte offset, be, wdata; go REQ if legal, else DONE with misalign=1.
REQ-019 Illegal: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; load func3 3/6/7; store func3 >=3.
REQ-020 REQ: mem_req=1 and mem_addr/be/we/wdata held stable; mem_ack=1 captures mem_rdata and goes DONE.
REQ-021 REQ: cycle counter SHALL reach ACK_TIMEOUT without ack -> bus_err=1, go DONE, mem_req drops.
REQ-022 DONE: done=1 exactly one cycle, then IDLE unconditionally; start ignored in DONE.
REQ-023 busy = (IDLE & start & LOAD/STORE opcode) | (state==REQ); busy=0 in DONE so core retires that cycle.
REQ-024 Min latency: accept cycle 0, REQ cycle 1 with ack, done cycle 2.
REQ-025 Store lanes: SB be=1<<addr[1:0], wdata={4{rs2[7:0]}}; SH be=addr[1]?1100:0011, wdata={2{rs2[15:0]}}; SW be=1111.
REQ-026 Loads SHALL drive mem_we=0 with same be pattern; result selects lane by offset; LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
REQ-027 load_data SHALL be 0 on store, misalign or bus_err; held until next DONE.
REQ-028 mem_ack outside REQ SHALL be ignored; non-LOAD/STORE opcode with start=1 SHALL keep IDLE, busy=0.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE, counter 0, all outputs 0, including mid-REQ (mem_req drops next edge).
REQ-030 No access SHALL start in the cycle rst_n=0.

Structure
REQ-031 Shared include: LOAD/STORE opcodes, func3 width codes, FSM state encoding.
REQ-032 Sub-module lsu_data_align SHALL hold combinational be/wdata generation and load extraction/extension.

Verification
REQ-033 SW addr=0x100, rs2=0xDEADBEEF, ack after 3 cycles -> mem_be=1111, mem_wdata=0xDEADBEEF, done cycle 5, busy high cycles 0-4.
REQ-034 LB addr=0x203, rdata=0x80112233, ack immediate -> mem_addr=0x200, be=1000, load_data=0xFFFFFF80; LBU -> 0x00000080.
REQ-035 LH addr=0x101 -> no mem_req, done next cycle, misalign=1, load_data=0.
REQ-036 LW, mem_ack never asserted -> mem_req high 16 cycles, then bus_err=1 with done, mem_req=0.
REQ-037 rst_n=0 during REQ, then SH addr=0x302 rs2=0x0000ABCD -> clean IDLE; be=1100, wdata=0xABCDABCD.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared opcodes, width codes, FSM encoding and legality check
package load_store_unit_pkg;
  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} lsu_state_e;
  function automatic logic access_illegal(input logic is_store, input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    return 1'b0;
      F3_H:    return off[0];
      F3_W:    return off != 2'b00;
      F3_BU:   return is_store;
      F3_HU:   return is_store | off[0];
      default: return 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/lsu_data_align.sv
// lsu_data_align: byte-lane enables, write-data replication and load lane extraction
module lsu_data_align
  import load_store_unit_pkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  func3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] store_data_i,
  input  logic [2:0]  ld_func3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        illegal_o,
  output logic [31:0] ld_data_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  // lane enables and replicated write data for the access being accepted
  always_comb begin
    be_o = func3_i[1:0] == 2'd0 ? 4'b0001 << off_i :
           func3_i[1:0] == 2'd1 ? (off_i[1] ? 4'b1100 : 4'b0011) :
           func3_i[1:0] == 2'd2 ? 4'b1111 : 4'b0000;
    wdata_o = func3_i[1:0] == 2'd0 ? {4{store_data_i[7:0]}} :
              func3_i[1:0] == 2'd1 ? {2{store_data_i[15:0]}} : store_data_i;
    illegal_o = access_illegal(is_store_i, func3_i, off_i);
  end
  // pick the addressed lane of the read word; func3[2] selects zero-extension
  always_comb begin
    byte_sel = rdata_i[{ld_off_i, 3'b000} +: 8];
    half_sel = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    ld_data_o = ld_func3_i[1:0] == 2'd0 ? {{24{~ld_func3_i[2] & byte_sel[7]}}, byte_sel} :
                ld_func3_i[1:0] == 2'd1 ? {{16{~ld_func3_i[2] & half_sel[15]}}, half_sel} : rdata_i;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store sequencer with ack timeout
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  lsu_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        is_store, is_ls, accept, illegal, timeout;
  logic [29:0] word_q;
  logic [1:0]  off_q;
  logic [2:0]  func3_q;
  logic        store_q, mem_req_q, mem_we_q, misalign_q, bus_err_q;
  logic [3:0]  be_q, be_n;
  logic [31:0] wdata_q, wdata_n, load_data_q, ld_ext;

  assign is_store = opcode == OP_STORE;
  assign is_ls    = is_store | (opcode == OP_LOAD);
  assign accept   = (state_q == S_IDLE) & start & is_ls;
  assign timeout  = cnt_q == 8'(ACK_TIMEOUT - 1);

  lsu_data_align u_align (
    .is_store_i  (is_store),
    .func3_i     (func3),
    .off_i       (addr[1:0]),
    .store_data_i(store_data),
    .ld_func3_i  (func3_q),
    .ld_off_i    (off_q),
    .rdata_i     (mem_rdata),
    .be_o        (be_n),
    .wdata_o     (wdata_n),
    .illegal_o   (illegal),
    .ld_data_o   (ld_ext)
  );

  // state and ack-wait counter registers
  always_ff @(posedge clk) begin
    state_q <= !rst_n ? S_IDLE : state_d;
    cnt_q   <= !rst_n ? 8'd0 : cnt_d;
  end

  // next state: illegal accesses skip the bus; REQ ends on ack or timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: state_d = accept ? (illegal ? S_DONE : S_REQ) : S_IDLE;
      S_REQ: begin
        state_d = (mem_ack | timeout) ? S_DONE : S_REQ;
        cnt_d   = (mem_ack | timeout) ? 8'd0 : cnt_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // core handshake; busy drops in DONE so the instruction retires that cycle
  always_comb begin
    busy = rst_n & (accept | (state_q == S_REQ));
    done = state_q == S_DONE;
  end

  // bus signals latched at accept and result flags captured on entry to DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q      <= '0;
      off_q       <= '0;
      func3_q     <= '0;
      store_q     <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      load_data_q <= '0;
    end else begin
      mem_req_q <= state_d == S_REQ;
      mem_we_q  <= (state_d == S_REQ) & (state_q == S_IDLE ? is_store : store_q);
      if (accept) begin
        word_q  <= addr[31:2];
        off_q   <= addr[1:0];
        func3_q <= func3;
        store_q <= is_store;
        be_q    <= be_n;
        wdata_q <= wdata_n;
      end
      if (state_d == S_DONE) begin
        misalign_q  <= state_q == S_IDLE;
        bus_err_q   <= (state_q == S_REQ) & ~mem_ack;
        load_data_q <= ((state_q == S_REQ) & mem_ack & ~store_q) ? ld_ext : 32'd0;
      end
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = {word_q, 2'b00};
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign misalign  = misalign_q;
  assign bus_err   = bus_err_q;
  assign load_data = load_data_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus reset and idle corner sequences
module tb_load_store_unit;
  localparam logic [4:0] OPL = 5'b00000;
  localparam logic [4:0] OPS = 5'b01000;

  logic        clk = 1'b0;
  logic        rst_n, start, mem_ack;
  logic [4:0]  opcode;
  logic [2:0]  func3;
  logic [31:0] addr, store_data, mem_rdata;
  logic        busy, done, misalign, bus_err, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          ack_at;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] maddr;
    logic        we;
    logic [31:0] ld;
    logic        mis;
    logic        berr;
    int          lat;
    int          reqc;
  } vec_t;

  vec_t vt[15];

  load_store_unit #(.ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .func3(func3),
    .addr(addr), .store_data(store_data), .busy(busy), .done(done),
    .load_data(load_data), .misalign(misalign), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    int req_cnt = 0;
    int cyc;
    @(negedge clk);
    start = 1'b1; opcode = v.op; func3 = v.f3; addr = v.addr;
    store_data = v.sd; mem_rdata = v.rdata; mem_ack = 1'b0;
    #1 chk($sformatf("v%0d busy_accept", idx), busy, 1);
    for (cyc = 1; cyc < 60; cyc++) begin
      @(negedge clk);
      if (done) break;
      chk($sformatf("v%0d busy c%0d", idx, cyc), busy, 1);
      if (mem_req) begin
        req_cnt++;
        chk($sformatf("v%0d be", idx), mem_be, v.be);
        chk($sformatf("v%0d addr", idx), mem_addr, v.maddr);
        chk($sformatf("v%0d we", idx), mem_we, v.we);
        if (v.op == OPS) chk($sformatf("v%0d wdata", idx), mem_wdata, v.wd);
      end
      mem_ack = mem_req && v.ack_at != 0 && req_cnt == v.ack_at;
    end
    chk($sformatf("v%0d done", idx), done, 1);
    chk($sformatf("v%0d latency", idx), cyc, v.lat);
    chk($sformatf("v%0d req_cycles", idx), req_cnt, v.reqc);
    chk($sformatf("v%0d busy_done", idx), busy, 0);
    chk($sformatf("v%0d req_done", idx), mem_req, 0);
    chk($sformatf("v%0d misalign", idx), misalign, v.mis);
    chk($sformatf("v%0d bus_err", idx), bus_err, v.berr);
    chk($sformatf("v%0d load_data", idx), load_data, v.ld);
    start = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d done_pulse", idx), done, 0);
    chk($sformatf("v%0d load_hold", idx), load_data, v.ld);
  endtask

  initial begin
    //          op   f3    addr          sd            rdata         ack be       wd            maddr         we    ld            mis   berr  lat reqc
    vt[0]  = '{OPS, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        4,  4'b1111, 32'hDEAD_BEEF, 32'h0000_0100, 1'b1, 32'h0,        1'b0, 1'b0, 5,  4};
    vt[1]  = '{OPL, 3'd0, 32'h0000_0203, 32'h0,        32'h8011_2233, 1,  4'b1000, 32'h0,        32'h0000_0200, 1'b0, 32'hFFFF_FF80, 1'b0, 1'b0, 2,  1};
    vt[2]  = '{OPL, 3'd4, 32'h0000_0203, 32'h0,        32'h8011_2233, 1,  4'b1000, 32'h0,        32'h0000_0200, 1'b0, 32'h0000_0080, 1'b0, 1'b0, 2,  1};
    vt[3]  = '{OPL, 3'd1, 32'h0000_0101, 32'h0,        32'h0,        1,  4'b0000, 32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1,  0};
    vt[4]  = '{OPL, 3'd2, 32'h0000_0400, 32'h0,        32'h1234_5678, 0,  4'b1111, 32'h0,        32'h0000_0400, 1'b0, 32'h0,        1'b0, 1'b1, 17, 16};
    vt[5]  = '{OPL, 3'd1, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 2,  4'b1100, 32'h0,        32'h0000_0100, 1'b0, 32'hFFFF_8001, 1'b0, 1'b0, 3,  2};
    vt[6]  = '{OPL, 3'd5, 32'h0000_0100, 32'h0,        32'h8001_F00F, 1,  4'b0011, 32'h0,        32'h0000_0100, 1'b0, 32'h0000_F00F, 1'b0, 1'b0, 2,  1};
    vt[7]  = '{OPL, 3'd2, 32'h0000_0104, 32'h0,        32'h1234_5678, 1,  4'b1111, 32'h0,        32'h0000_0104, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 2,  1};
    vt[8]  = '{OPS, 3'd0, 32'h0000_0501, 32'h1122_3344, 32'hFFFF_FFFF, 1,  4'b0010, 32'h4444_4444, 32'h0000_0500, 1'b1, 32'h0,        1'b0, 1'b0, 2,  1};
    vt[9]  = '{OPS, 3'd2, 32'h0000_0102, 32'h1,        32'h0,        1,  4'b0000, 32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1,  0};
    vt[10] = '{OPL, 3'd3, 32'h0000_0000, 32'h0,        32'h0,        1,  4'b0000, 32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1,  0};
    vt[11] = '{OPS, 3'd4, 32'h0000_0000, 32'h0,        32'h0,        1,  4'b0000, 32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1,  0};
    vt[12] = '{OPL, 3'd0, 32'h0000_0201, 32'h0,        32'h0000_7F00, 1,  4'b0010, 32'h0,        32'h0000_0200, 1'b0, 32'h0000_007F, 1'b0, 1'b0, 2,  1};
    vt[13] = '{OPL, 3'd4, 32'h0000_0200, 32'h0,        32'hFFFF_FFFE, 3,  4'b0001, 32'h0,        32'h0000_0200, 1'b0, 32'h0000_00FE, 1'b0, 1'b0, 4,  3};
    vt[14] = '{OPS, 3'd1, 32'h0000_0302, 32'h0000_ABCD, 32'h0,        1,  4'b1100, 32'hABCD_ABCD, 32'h0000_0300, 1'b1, 32'h0,        1'b0, 1'b0, 2,  1};

    rst_n = 1'b0; start = 1'b0; opcode = '0; func3 = '0; addr = '0;
    store_data = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_be", mem_be, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst load_data", load_data, 0);
    chk("rst flags", {misalign, bus_err}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run(vt[i], i);

    // non load/store opcode must not start an access
    @(negedge clk);
    start = 1'b1; opcode = 5'b01100; func3 = 3'd2; addr = 32'h100;
    #1 chk("alu busy", busy, 0);
    @(negedge clk);
    chk("alu mem_req", mem_req, 0);
    chk("alu done", done, 0);
    start = 1'b0;

    // stray ack while idle is ignored
    mem_ack = 1'b1;
    @(negedge clk);
    chk("idle ack done", done, 0);
    chk("idle ack req", mem_req, 0);
    mem_ack = 1'b0;

    // reset in the middle of REQ with start still asserted
    @(negedge clk);
    start = 1'b1; opcode = OPL; func3 = 3'd2; addr = 32'h600;
    repeat (3) @(negedge clk);
    chk("midreq req", mem_req, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreq rst req", mem_req, 0);
    chk("midreq rst busy", busy, 0);
    chk("midreq rst done", done, 0);
    @(negedge clk);
    chk("rst hold no start", mem_req, 0);
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("post rst req", mem_req, 0);
    chk("post rst done", done, 0);
    chk("post rst be", mem_be, 0);
    chk("post rst bus_err", bus_err, 0);
    run(vt[14], 14);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
